// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control unit.
// One instruction is in flight at a time. The state register advances through
// fetch, decode and per-class execute/writeback states. Datapath controls are
// a Moore decode of the current state, except the BEQ PC write, which follows
// the live ALU zero flag. Cycle and retired-instruction counters are kept for
// bring-up and debug.
module mc_ctrl_fsm #(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             pc_we,
    output logic             iord,
    output logic             mem_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REX  = 4'd6,
        S_RWB  = 4'd7,
        S_BEQ  = 4'd8,
        S_JMP  = 4'd9,
        S_IEX  = 4'd10,
        S_IWB  = 4'd11,
        S_HALT = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t cur;

    // Raw (ungated) write enables from the state decode.
    logic pc_we_raw;
    logic mem_we_raw;
    logic ir_we_raw;
    logic reg_we_raw;
    logic illegal_raw;

    // Opcodes that have a dedicated execute path. HALT_OP is handled separately.
    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // Next-state rule. HALT_OP is tested first so a HALT_OP that aliases a
    // supported opcode still parks the machine.
    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        state_t n;
        n = S_IF;
        case (s)
            S_IF:   n = S_ID;
            S_ID: begin
                if (op == HALT_OP)       n = S_HALT;
                else if (op == OP_RTYPE) n = S_REX;
                else if (op == OP_LW)    n = S_MADR;
                else if (op == OP_SW)    n = S_MADR;
                else if (op == OP_BEQ)   n = S_BEQ;
                else if (op == OP_J)     n = S_JMP;
                else if (op == OP_ADDI)  n = S_IEX;
                else                     n = S_IF;
            end
            S_MADR: n = (op == OP_LW) ? S_MRD : S_MWR;
            S_MRD:  n = S_MWB;
            S_REX:  n = S_RWB;
            S_IEX:  n = S_IWB;
            S_MWB, S_MWR, S_RWB, S_BEQ, S_JMP, S_IWB: n = S_IF;
            S_HALT: n = S_HALT;
            default: n = S_IF;
        endcase
        return n;
    endfunction

    // An instruction retires on the edge leaving its final state, or on the
    // edge that enters HALT.
    function automatic logic retires(input state_t s, input logic [5:0] op);
        logic r;
        case (s)
            S_MWB, S_MWR, S_RWB, S_BEQ, S_JMP, S_IWB: r = 1'b1;
            S_ID:    r = (op == HALT_OP);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // State register and debug counters; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= S_IF;
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cur <= next_state(cur, opcode);
            if (cur != S_HALT)
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (retires(cur, opcode))
                ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end

    // Moore decode of datapath controls from the current state.
    always_comb begin
        pc_we_raw   = 1'b0;
        mem_we_raw  = 1'b0;
        ir_we_raw   = 1'b0;
        reg_we_raw  = 1'b0;
        illegal_raw = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_src      = 2'b00;
        halted      = 1'b0;
        case (cur)
            S_IF: begin
                ir_we_raw = 1'b1;
                pc_we_raw = 1'b1;
                alu_src_b = 2'b01;
            end
            S_ID: begin
                alu_src_b   = 2'b11;
                illegal_raw = !is_supported(opcode) && (opcode != HALT_OP);
            end
            S_MADR, S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MRD: begin
                iord = 1'b1;
            end
            S_MWR: begin
                iord       = 1'b1;
                mem_we_raw = 1'b1;
            end
            S_MWB: begin
                reg_we_raw = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b1;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_we_raw = 1'b1;
                reg_dst    = 1'b1;
            end
            S_IWB: begin
                reg_we_raw = 1'b1;
                reg_dst    = 1'b0;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_we_raw = zero;
            end
            S_JMP: begin
                pc_src    = 2'b10;
                pc_we_raw = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    // Enables and the illegal pulse are held low for the whole time reset is
    // asserted, even though the state register already reads IF.
    assign pc_we      = pc_we_raw   & ~reset;
    assign mem_we     = mem_we_raw  & ~reset;
    assign ir_we      = ir_we_raw   & ~reset;
    assign reg_we     = reg_we_raw  & ~reset;
    assign illegal_op = illegal_raw & ~reset;
    assign state      = cur;

endmodule
